parity_frame_rx: RTL and testbench
==================================

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the number of data bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  as its reset, which is synchronous and active-high.
REQ-005 The block SHALL have port bit_en  input  1  as the bit-time strobe; sin is sampled only on edges where bit_en=1.
REQ-006 The block SHALL have port sin  input  1  as the serial line input, idle high.
REQ-007 The block SHALL have port data  output  DATA_BITS  as the last received data word.
REQ-008 The block SHALL have port valid  output  1  as a one-cycle pulse marking a completed frame.
REQ-009 The block SHALL have port parity_err  output  1  as the parity check result of the last frame.
REQ-010 The block SHALL have port frame_err  output  1  as the stop-bit check result of the last frame.
REQ-011 The block SHALL have port busy  output  1  which is high while a frame is in progress.

Function
REQ-012 The frame format SHALL be: start bit (0), DATA_BITS data bits LSB first, one parity bit, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-014 In IDLE, a bit_en sample with sin=0 SHALL move the FSM to DATA, and a sample with sin=1 SHALL keep it in IDLE.
REQ-015 In DATA, each bit_en sample SHALL shift sin into the receive shift register LSB first; after DATA_BITS samples the FSM SHALL move to PARITY.
REQ-016 An internal bit counter SHALL be sized ceil(log2(DATA_BITS+1)) bits, SHALL clear on entry to DATA, and SHALL NOT wrap within a frame.
REQ-017 In PARITY, one bit_en sample SHALL capture the parity bit and move the FSM to STOP.
REQ-018 In STOP, one bit_en sample SHALL complete the frame and return the FSM to IDLE.
REQ-019 When bit_en=0, the FSM, bit counter and shift register SHALL hold their values.
REQ-020 On the edge that samples the stop bit, the block SHALL load data from the shift register, set valid=1 for exactly the following cycle, and update both error flags.
REQ-021 parity_err SHALL equal (XOR of all data bits) XOR (parity bit) XOR ODD_PARITY.
REQ-022 frame_err SHALL be 1 if and only if the sampled stop bit is 0.
REQ-023 valid SHALL pulse even when parity_err or frame_err is set; data SHALL still be delivered.
REQ-024 data, parity_err and frame_err SHALL hold their values until the next valid pulse.
REQ-025 busy SHALL be 1 exactly when the FSM is in DATA, PARITY or STOP.
REQ-026 The block SHALL accept back-to-back frames: a start bit on the first bit_en sample after the stop bit SHALL be detected.
REQ-027 The block SHALL NOT re-check the start bit mid-frame and SHALL NOT support break detection.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL set FSM=IDLE, bit counter=0, shift register=0, data=0, valid=0, parity_err=0, frame_err=0 and busy=0.
REQ-029 Reset SHALL take priority over bit_en and sin.
REQ-030 A reset mid-frame SHALL discard the partial frame without producing any valid pulse.

Verification
REQ-031 With bit_en=1 every cycle and defaults, the bench SHALL send sin sequence 0,1,0,1,0,0,1,0,1,0,1 and check data=0xA5, valid high for exactly 1 cycle, parity_err=0, frame_err=0.
REQ-032 The bench SHALL send byte 0xA5 with parity bit 1 and check valid=1, data=0xA5, parity_err=1, frame_err=0.
REQ-033 The bench SHALL send byte 0xA5 with parity 0 and stop bit 0 and check frame_err=1, parity_err=0, data=0xA5.
REQ-034 The bench SHALL assert rst after 3 data bits, check busy=0 and no valid pulse, then send 0x3C with parity 0 and check data=0x3C with no errors.
REQ-035 The bench SHALL drive bit_en every 4th cycle with sin held 4 cycles per bit, send 0xA5, and check the same result as REQ-031 with exactly one valid pulse.
REQ-036 The bench SHALL send back-to-back frames 0x01 (parity 1) and 0xFF (parity 0) and check two valid pulses delivering 0x01 then 0xFF, both with no errors.

Source files
------------

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Sampling happens only on edges qualified by the bit_en strobe; results hold until the next frame.
//
// state  | meaning
// IDLE   | waiting for a start bit (sin=0 on a bit_en sample)
// DATA   | shifting in DATA_BITS data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | sampling the stop bit and publishing the frame
module parity_frame_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
      valid   <= frame_done;
      if (frame_done) begin
        data       <= shreg;
        parity_err <= (^shreg) ^ par_bit ^ ODD_PARITY;
        frame_err  <= ~sin;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    frame_done  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          // Shift right with new bit entering at the MSB so the first bit ends up at bit 0.
          shreg_nxt                = shreg >> 1;
          shreg_nxt[DATA_BITS-1]   = sin;
          bit_cnt_nxt              = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) state_nxt = PARITY;
        end
        PARITY: begin
          par_bit_nxt = sin;
          state_nxt   = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: stimulus pushes expected frames, a negedge monitor pops and checks them.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       sin;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  logic prev_valid = 1'b0;

  parity_frame_rx #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .sin        (sin),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid pulse must be one cycle wide and match the oldest expected frame.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      exp_t e;
      n_valid++;
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", {24'd0, data}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
      end
    end
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int per);
    sin = b;
    for (int i = 1; i < per; i++) begin
      bit_en = 1'b0;
      tick();
    end
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int per,
                            input logic exp_perr, input logic exp_ferr);
    exp_t e;
    e.data = d;
    e.perr = exp_perr;
    e.ferr = exp_ferr;
    exp_q.push_back(e);
    send_bit(1'b0, per);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(d[i], per);
    send_bit(par, per);
    send_bit(stop, per);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic idle(input int n);
    sin    = 1'b1;
    bit_en = 1'b1;
    repeat (n) tick();
    bit_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] seq;
    int          v0;
    rst    = 1'b1;
    bit_en = 1'b1;
    sin    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bit_en = 1'b0;
    sin = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    idle(3);

    // Literal line sequence, bit_en every cycle: start, A5 LSB first, parity 0, stop 1.
    seq = 11'b1_0_10100101_0;
    begin
      exp_t e;
      e.data = 8'hA5; e.perr = 1'b0; e.ferr = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) send_bit(seq[i], 1);
    idle(3);

    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    idle(3);
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    idle(5);
    check("hold_data", {24'd0, data}, 32'h0000_00A5);
    check("hold_ferr", {31'd0, frame_err}, 32'd1);

    // Reset after three data bits, with bit_en and sin=0 active to show reset priority.
    v0 = n_valid;
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst    = 1'b1;
    bit_en = 1'b1;
    sin    = 1'b0;
    tick();
    rst    = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, data}, 32'd0);
    idle(12);
    check("mid_rst_no_valid", n_valid, v0);
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    idle(3);

    // Slow strobe: bit_en every 4th cycle, sin held 4 cycles per bit.
    v0 = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    idle(3);
    check("slow_one_pulse", n_valid, v0 + 1);

    // Back-to-back frames with no idle gap.
    v0 = n_valid;
    send_frame(8'h01, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    idle(3);
    check("b2b_two_pulses", n_valid, v0 + 2);

    check("total_pulses", n_valid, 7);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
